// File: rtl/layer_feeder.sv
// Collects one activation vector into a registered bank, waits for the node
// datapath to settle, then presents the ReLU-clamped node result.
module layer_feeder #(
  parameter int unsigned NUM_IN = 30,
  parameter int unsigned SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [32*NUM_IN-1:0]   a_bus,
  input  logic [31:0]            node_out,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   len_err
);

  localparam int unsigned DW       = 32;
  localparam int unsigned IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LAST_IDX = NUM_IN - 1;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               wr_en;
  logic               zero_tail;
  logic               capture;
  logic               len_err_d;
  logic               out_valid_d;
  logic               in_ready_d;
  logic [31:0]        out_data_d;

  logic xfer;
  logic at_last;
  logic end_vec;

  // in_ready is only ever high in FILL, so a transfer implies FILL
  assign xfer    = in_valid & in_ready;
  assign at_last = (idx_q == IDX_W'(LAST_IDX));
  assign end_vec = xfer & (in_last | at_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:   if (end_vec)              state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0)          state_d = ST_HOLD;
      ST_HOLD:   if (out_valid & out_ready) state_d = ST_FILL;
      default:                             state_d = ST_FILL;
    endcase
  end

  // Control decode and next values for the registered outputs
  always_comb begin
    wr_en       = 1'b0;
    zero_tail   = 1'b0;
    capture     = 1'b0;
    len_err_d   = 1'b0;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid;
    in_ready_d  = (state_d == ST_FILL);
    case (state_q)
      ST_FILL: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (end_vec) begin
            idx_d     = '0;
            cnt_d     = CNT_W'(SETTLE - 1);
            zero_tail = in_last & ~at_last;
            len_err_d = in_last ^ at_last;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          capture     = 1'b1;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  // Sign bit set (including -0.0) clamps the result to +0.0
  assign out_data_d = capture ? (node_out[31] ? 32'd0 : node_out) : out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      len_err   <= 1'b0;
      out_data  <= '0;
    end else begin
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      len_err   <= len_err_d;
      out_data  <= out_data_d;
    end
  end

  // Activation bank; a short vector clears every word past the last one written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_bus <= '0;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (wr_en && (idx_q == IDX_W'(k)))
          a_bus[k*DW +: DW] <= in_data;
        else if (zero_tail && (IDX_W'(k) > idx_q))
          a_bus[k*DW +: DW] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_layer_feeder.sv
// Directed self-checking bench for layer_feeder with hand-computed expectations.
module tb_layer_feeder;

  localparam int unsigned NUM_IN = 30;
  localparam int unsigned SETTLE = 4;

  logic                 clk;
  logic                 rst_n;
  logic [31:0]          in_data;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [32*NUM_IN-1:0] a_bus;
  logic [31:0]          node_out;
  logic [31:0]          out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 len_err;
  logic [31:0]          node_val;

  int checks = 0;
  int errors = 0;
  int lat;

  layer_feeder #(.NUM_IN(NUM_IN), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .a_bus     (a_bus),
    .node_out  (node_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .len_err   (len_err)
  );

  // Node stand-in: returns whatever result the current test expects
  assign node_out = node_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return a_bus[32*k +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'h1);
    step();
  endtask

  task automatic send_vec(input logic [31:0] base, input logic [31:0] inc,
                          input int n, input logic use_last);
    for (int i = 0; i < n; i++)
      send_word(base + inc * 32'(i), use_last && (i == n - 1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!out_valid && l < 50) begin
      step();
      l++;
    end
    if (!out_valid) l = 999;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    node_val  = 32'h41F0_0000;

    // Reset state
    repeat (3) step();
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_len_err",   32'(len_err),   32'h0);
    check("rst_a_bus_w0",  word(0),        32'h0);
    rst_n = 1'b1;
    step();
    check("in_ready_after_rst", 32'(in_ready), 32'h1);

    // Thirty 1.0 activations, node returns 30.0
    send_vec(32'h3F80_0000, 32'h0, 30, 1'b1);
    check("t1_in_ready_low", 32'(in_ready), 32'h0);
    check("t1_len_err",      32'(len_err),  32'h0);
    wait_valid(lat);
    check("t1_latency",  32'(lat), 32'd4);
    check("t1_out_data", out_data, 32'h41F0_0000);
    check("t1_w0",       word(0),  32'h3F80_0000);
    check("t1_w29",      word(29), 32'h3F80_0000);
    step();
    check("t1_out_valid_drop", 32'(out_valid), 32'h0);
    check("t1_in_ready_back",  32'(in_ready),  32'h1);

    // Negative results clamp to +0.0
    node_val = 32'hBF80_0000;
    send_vec(32'h4000_0000, 32'h1, 30, 1'b1);
    wait_valid(lat);
    check("t2_neg_one", out_data, 32'h0);
    check("t2_w29",     word(29), 32'h4000_001D);
    step();
    node_val = 32'h8000_0000;
    send_vec(32'h4000_0000, 32'h1, 30, 1'b1);
    wait_valid(lat);
    check("t2_neg_zero", out_data, 32'h0);
    step();

    // Short vector: in_last on word 9
    node_val = 32'h3F00_0000;
    send_vec(32'h3E00_0000, 32'h1, 10, 1'b1);
    check("t3_len_err_pulse", 32'(len_err), 32'h1);
    step();
    check("t3_len_err_drop", 32'(len_err), 32'h0);
    wait_valid(lat);
    check("t3_latency", 32'(lat), 32'd3);
    for (int k = 0; k < 30; k++)
      check($sformatf("t3_w%0d", k), word(k), (k < 10) ? 32'h3E00_0000 + 32'(k) : 32'h0);
    check("t3_out_data", out_data, 32'h3F00_0000);
    step();
    check("t3_single_result", 32'(out_valid), 32'h0);

    // Long vector with downstream stalled in HOLD
    node_val  = 32'h4200_0000;
    out_ready = 1'b0;
    send_vec(32'h5000_0000, 32'h1, 30, 1'b0);
    check("t4_len_err_pulse", 32'(len_err),  32'h1);
    check("t4_in_ready_low",  32'(in_ready), 32'h0);
    in_data  = 32'hAAAA_0030;
    in_valid = 1'b1;
    step();
    check("t4_len_err_drop", 32'(len_err), 32'h0);
    wait_valid(lat);
    check("t4_latency", 32'(lat), 32'd3);
    node_val = 32'h1234_5678;
    for (int c = 0; c < 20; c++) begin
      check("t4_hold_valid",    32'(out_valid), 32'h1);
      check("t4_hold_data",     out_data,       32'h4200_0000);
      check("t4_hold_in_ready", 32'(in_ready),  32'h0);
      check("t4_hold_w0",       word(0),        32'h5000_0000);
      check("t4_hold_w29",      word(29),       32'h5000_001D);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t4_accept_valid",    32'(out_valid), 32'h0);
    check("t4_accept_in_ready", 32'(in_ready),  32'h1);
    send_word(32'hAAAA_0030, 1'b0);
    check("t4_stalled_as_w0", word(0),  32'hAAAA_0030);
    check("t4_w29_kept",      word(29), 32'h5000_001D);
    node_val = 32'h4040_0000;
    send_vec(32'h6000_0001, 32'h1, 29, 1'b1);
    check("t4_next_len_err", 32'(len_err), 32'h0);
    wait_valid(lat);
    check("t4_next_latency", 32'(lat), 32'd4);
    check("t4_next_out",     out_data, 32'h4040_0000);
    check("t4_next_w29",     word(29), 32'h6000_001D);
    step();

    // Reset in the middle of SETTLE
    node_val = 32'h4100_0000;
    send_vec(32'h7000_0000, 32'h1, 30, 1'b1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'h0);
    check("t5_rst_in_ready",  32'(in_ready),  32'h0);
    check("t5_rst_out_data",  out_data,       32'h0);
    check("t5_rst_len_err",   32'(len_err),   32'h0);
    check("t5_rst_w0",        word(0),        32'h0);
    check("t5_rst_w29",       word(29),       32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("t5_in_ready_rise", 32'(in_ready), 32'h1);
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) lat++;
      step();
    end
    check("t5_no_stale_valid", 32'(lat), 32'd0);
    node_val = 32'h4120_0000;
    send_vec(32'h3F00_0000, 32'h1, 30, 1'b1);
    wait_valid(lat);
    check("t5_fresh_latency", 32'(lat), 32'd4);
    check("t5_fresh_out",     out_data, 32'h4120_0000);
    check("t5_fresh_w29",     word(29), 32'h3F00_001D);
    step();
    check("t5_fresh_accept",  32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_feeder.md
LAYER_FEEDER -- requirements
Module: layer_feeder

Interface
REQ-001 Parameter NUM_IN, default 30: number of 32-bit activations collected per node evaluation.
REQ-002 Parameter SETTLE, default 4: cycles allowed for the combinational node datapath to settle before capture (legal range 1-15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  32  IEEE-754 single-precision activation from the previous layer.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_last  input  1  marks the final activation of a vector; qualified by in_valid.
REQ-008 in_ready  output  1  the block accepts in_data this cycle.
REQ-009 a_bus  output  32*NUM_IN  registered activation bank driven to the node; word k is at bits [32k+31:32k].
REQ-010 node_out  input  32  float result returned by the node.
REQ-011 out_data  output  32  captured node result with ReLU enforced.
REQ-012 out_valid  output  1  out_data is valid and held until accepted.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 len_err  output  1  one-cycle pulse on a vector-length mismatch.

Function
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-016 The FSM SHALL have three states: FILL (collecting), SETTLE (waiting), HOLD (result presented).
REQ-017 FILL: in_ready = 1, and each transfer SHALL write in_data to bank word idx and then increment idx (range 0..NUM_IN-1).
REQ-018 Transfer with idx = NUM_IN-1 and in_last = 1: write the word, clear idx, load the settle counter with SETTLE-1, and go to SETTLE.
REQ-019 Transfer with in_last = 1 and idx < NUM_IN-1 (short vector): pulse len_err, write the word, zero-fill the remaining words idx+1..NUM_IN-1 in the same cycle, clear idx, and go to SETTLE.
REQ-020 Transfer with idx = NUM_IN-1 and in_last = 0 (long vector): pulse len_err and treat the transfer as the last word; further words SHALL wait until the FSM returns to FILL.
REQ-021 SETTLE: in_ready = 0 and the bank SHALL stay stable; the counter decrements each cycle, and when it is 0 the block captures node_out and goes to HOLD.
REQ-022 Capture SHALL set out_data = 32'd0 when node_out[31] = 1, otherwise out_data = node_out, so -0.0 becomes +0.0.
REQ-023 HOLD: out_valid = 1 and in_ready = 0; out_data and a_bus SHALL stay stable until out_valid and out_ready are both 1 on an edge.
REQ-024 On the accepting edge of REQ-023, out_valid SHALL drop and the FSM SHALL return to FILL, with in_ready = 1 from the next cycle.
REQ-025 Latency from the last-word transfer edge to out_valid = 1 SHALL be exactly SETTLE cycles.
REQ-026 If out_ready is already 1 when out_valid rises, acceptance SHALL occur on that first HOLD edge.
REQ-027 in_ready SHALL be a registered function of state only and SHALL NOT depend combinationally on in_valid or out_ready.
REQ-028 len_err SHALL be high for exactly the one cycle after the offending transfer edge.

Reset
REQ-029 rst_n = 0 SHALL immediately force: state FILL, idx 0, settle counter 0, a_bus all zero, out_data 0, out_valid 0, len_err 0, in_ready 0.
REQ-030 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-031 Reset asserted during SETTLE or HOLD SHALL discard any partial or pending result, and no out_valid SHALL follow for that vector.

Verification
REQ-032 Stream 30 words of 0x3F800000 (1.0) with in_last on word 29, node model = sum of inputs (0x41F00000), out_ready = 1 -> out_valid rises 4 cycles after the last transfer, out_data = 0x41F00000, in_ready returns next cycle.
REQ-033 Node model returns 0xBF800000 (-1.0) -> out_data = 0x00000000; node returns 0x80000000 -> out_data = 0x00000000.
REQ-034 in_last on word 9 -> len_err pulses once, words 10-29 of a_bus = 0, and one result is produced.
REQ-035 in_last held at 0 for 31 words -> len_err pulses at word 29; word 30 stalls (in_ready = 0) and is accepted as word 0 of the next vector.
REQ-036 out_ready held at 0 for 20 cycles in HOLD -> out_valid, out_data and a_bus stable throughout, and no input accepted; it completes on the first out_ready = 1 edge.
REQ-037 rst_n pulsed low in mid-SETTLE -> all outputs 0 asynchronously, no out_valid afterward, and a fresh 30-word vector then completes normally.
